tea_encrypt_iter: RTL and testbench

Iterative TEA block encryptor: the encrypt-side counterpart of the team's single-round TEA decryption stage. It accepts one 64-bit plaintext and a 128-bit key over a valid/ready handshake. It runs ROUNDS encryption rounds, one round per clock, through a single round datapath. It then presents the 64-bit ciphertext over a valid/ready handshake. Intended as the cipher source feeding the decrypt pipeline, and as its round-trip checker.

---
 rtl/tea_pkg.sv | 33 +++
 rtl/tea_encrypt_iter_if.sv | 29 ++
 rtl/tea_enc_round.sv | 34 +++
 rtl/tea_encrypt_iter.sv | 126 ++++++++++++
 tb/tb_tea_encrypt_iter.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/tea_pkg.sv
// ---------------------------------------------------------------------------
// tea_pkg
// Shared TEA constants and types for the encrypt (and matching decrypt) side.
//   TEA_DELTA  : per-round sum increment
//   TEA_SUM32  : sum after 32 encryption rounds (decrypt starting sum)
//   K*_LSB     : bit position of each 32-bit key word inside the 128-bit key
//   state_e    : iterative-engine FSM states
//   block_t    : 64-bit cipher block {v0, v1}
// ---------------------------------------------------------------------------
package tea_pkg;

    localparam logic [31:0] TEA_DELTA = 32'h9E3779B9;
    localparam logic [31:0] TEA_SUM32 = 32'hC6EF3720;

    // k0 is the most significant key word, k3 the least significant
    localparam int K0_LSB = 96;
    localparam int K1_LSB = 64;
    localparam int K2_LSB = 32;
    localparam int K3_LSB = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef logic [63:0] block_t;

    function automatic logic [31:0] key_word(input logic [127:0] key, input int lsb);
        return key[lsb +: 32];
    endfunction

endpackage

// File: rtl/tea_encrypt_iter_if.sv
// ---------------------------------------------------------------------------
// tea_encrypt_iter_if
// Input job handshake (plaintext + key) and output ciphertext handshake.
//   master : the side that offers jobs and consumes ciphertext
//   slave  : the encryptor
// Signals: in_valid, in_ready, in_data[63:0], in_key[127:0],
//          out_valid, out_ready, out_data[63:0]
// ---------------------------------------------------------------------------
interface tea_encrypt_iter_if
    import tea_pkg::*;
;
    logic         in_valid;
    logic         in_ready;
    block_t       in_data;
    logic [127:0] in_key;
    logic         out_valid;
    logic         out_ready;
    block_t       out_data;

    modport master (
        output in_valid, in_data, in_key, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_key, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/tea_enc_round.sv
// ---------------------------------------------------------------------------
// tea_enc_round
// One combinational TEA encryption round (one Feistel cycle). Structured as
// the mirror image of the decrypt round so both can be checked against each
// other.
//   i_v0, i_v1 : current half-blocks
//   i_key      : 128-bit key {k0, k1, k2, k3}
//   i_sum      : already-incremented sum for this round
//   o_v0, o_v1 : half-blocks after the round (o_v1 uses the new o_v0)
// All arithmetic is modulo 2^32; shifts are logical.
// ---------------------------------------------------------------------------
module tea_enc_round
    import tea_pkg::*;
(
    input  logic [31:0]  i_v0,
    input  logic [31:0]  i_v1,
    input  logic [127:0] i_key,
    input  logic [31:0]  i_sum,
    output logic [31:0]  o_v0,
    output logic [31:0]  o_v1
);
    logic [31:0] w_k0, w_k1, w_k2, w_k3;
    logic [31:0] w_v0;

    assign w_k0 = key_word(i_key, K0_LSB);
    assign w_k1 = key_word(i_key, K1_LSB);
    assign w_k2 = key_word(i_key, K2_LSB);
    assign w_k3 = key_word(i_key, K3_LSB);

    assign w_v0 = i_v0 + (((i_v1 << 4) + w_k0) ^ (i_v1 + i_sum) ^ ((i_v1 >> 5) + w_k1));
    assign o_v0 = w_v0;
    assign o_v1 = i_v1 + (((w_v0 << 4) + w_k2) ^ (w_v0 + i_sum) ^ ((w_v0 >> 5) + w_k3));

endmodule

// File: rtl/tea_encrypt_iter.sv
// ---------------------------------------------------------------------------
// tea_encrypt_iter
// Iterative TEA block encryptor: accepts one plaintext/key job, runs ROUNDS
// rounds (one per clock) through a single round datapath, then holds the
// ciphertext until the consumer takes it. Jobs never overlap.
//   clk   : clock, all state on rising edge
//   rst_n : asynchronous active-low reset
//   bus   : job/ciphertext handshakes (slave side)
//   busy  : high while a job is running or its result is waiting
// Latency: accept edge + ROUNDS edges before out_valid rises.
// ---------------------------------------------------------------------------
module tea_encrypt_iter
    import tea_pkg::*;
#(
    parameter int unsigned ROUNDS = 32,
    parameter logic [31:0] DELTA  = TEA_DELTA
) (
    input  logic               clk,
    input  logic               rst_n,
    tea_encrypt_iter_if.slave  bus,
    output logic               busy
);
    localparam logic [7:0] LAST_RCNT = 8'(ROUNDS - 1);

    state_e       r_state;
    state_e       w_state_next;
    logic [31:0]  r_v0, r_v1, r_sum;
    logic [7:0]   r_rcnt;
    logic [127:0] r_key;

    logic         w_accept;
    logic         w_round;
    logic         w_in_ready;
    logic         w_out_valid;
    logic         w_busy;
    logic [31:0]  w_sum_next;
    logic [31:0]  w_v0_next, w_v1_next;

    assign w_sum_next = r_sum + DELTA;

    tea_enc_round u_round (
        .i_v0  (r_v0),
        .i_v1  (r_v1),
        .i_key (r_key),
        .i_sum (w_sum_next),
        .o_v0  (w_v0_next),
        .o_v1  (w_v1_next)
    );

    // NOTE: flops use non-blocking assignments so every register samples the
    // pre-edge values of its peers, regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_round      = 1'b0;
        w_in_ready   = 1'b0;
        w_out_valid  = 1'b0;
        w_busy       = 1'b0;
        case (r_state)
            IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = RUN;
                end
            end
            RUN: begin
                w_busy  = 1'b1;
                w_round = 1'b1;
                if (r_rcnt == LAST_RCNT) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                w_busy      = 1'b1;
                w_out_valid = 1'b1;
                // Only the output handshake is honoured here; a pending job
                // waits for the IDLE cycle that follows.
                if (bus.out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v0   <= '0;
            r_v1   <= '0;
            r_sum  <= '0;
            r_rcnt <= '0;
            r_key  <= '0;
        end else if (w_accept) begin
            r_v0   <= bus.in_data[63:32];
            r_v1   <= bus.in_data[31:0];
            r_key  <= bus.in_key;
            r_sum  <= '0;
            r_rcnt <= '0;
        end else if (w_round) begin
            r_v0   <= w_v0_next;
            r_v1   <= w_v1_next;
            r_sum  <= w_sum_next;
            r_rcnt <= r_rcnt + 8'd1;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    // Gated so intermediate round values never appear on the output.
    assign bus.out_data  = w_out_valid ? {r_v0, r_v1} : '0;
    assign busy          = w_busy;

endmodule

// File: tb/tb_tea_encrypt_iter.sv
// ---------------------------------------------------------------------------
// tb_tea_encrypt_iter
// Directed bench for tea_encrypt_iter: a 32-round instance and a 1-round
// instance. Known-answer vectors, round trips through a decrypt model,
// output back-pressure, mid-job reset and back-to-back throughput.
// ---------------------------------------------------------------------------
module tb_tea_encrypt_iter;
    import tea_pkg::*;

    localparam logic [127:0] KEY_A      = 128'h00010203_04050607_08090A0B_0C0D0E0F;
    localparam block_t       CT_ZERO    = 64'h41EA3A0A_94BAA940;
    // One round, key 0, plaintext 0: v0' = DELTA, v1' worked out by hand
    localparam block_t       CT_ZERO_R1 = 64'h9E3779B9_DBE8D32F;
    localparam block_t       PT_B       = 64'h01234567_89ABCDEF;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy32, busy1;
    int   checks = 0;
    int   errors = 0;

    tea_encrypt_iter_if bus32 ();
    tea_encrypt_iter_if bus1 ();

    tea_encrypt_iter #(.ROUNDS(32), .DELTA(TEA_DELTA)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus32),
        .busy  (busy32)
    );

    tea_encrypt_iter #(.ROUNDS(1), .DELTA(TEA_DELTA)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1),
        .busy  (busy1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference decryption: 32 rounds starting from TEA_SUM32
    function automatic block_t tea_dec(input block_t c, input logic [127:0] k);
        logic [31:0] v0, v1, sum;
        v0  = c[63:32];
        v1  = c[31:0];
        sum = TEA_SUM32;
        for (int i = 0; i < 32; i++) begin
            v1  = v1 - (((v0 << 4) + k[63:32]) ^ (v0 + sum) ^ ((v0 >> 5) + k[31:0]));
            v0  = v0 - (((v1 << 4) + k[127:96]) ^ (v1 + sum) ^ ((v1 >> 5) + k[95:64]));
            sum = sum - TEA_DELTA;
        end
        return {v0, v1};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offers a job until accepted; returns just after the accepting edge.
    task automatic accept32(input block_t pt, input logic [127:0] key, output int ok);
        ok = 0;
        bus32.in_valid = 1'b1;
        bus32.in_data  = pt;
        bus32.in_key   = key;
        for (int i = 0; i < 100 && ok == 0; i++) begin
            if (bus32.in_ready) ok = 1;
            step();
        end
        bus32.in_valid = 1'b0;
    endtask

    // Counts edges from the accepting edge (inclusive) until out_valid.
    task automatic wait_done32(output int edges);
        edges = 1;
        while (!bus32.out_valid && edges < 200) begin
            step();
            edges++;
        end
    endtask

    task automatic take32();
        bus32.out_ready = 1'b1;
        step();
        bus32.out_ready = 1'b0;
    endtask

    initial begin
        int     ok;
        int     n;
        block_t pt;
        block_t held;

        bus32.in_valid = 1'b0; bus32.in_data = '0; bus32.in_key = '0; bus32.out_ready = 1'b0;
        bus1.in_valid  = 1'b0; bus1.in_data  = '0; bus1.in_key  = '0; bus1.out_ready  = 1'b0;

        // Reset state
        #1;
        check("rst_in_ready", 64'(bus32.in_ready), 64'd1);
        check("rst_out_valid", 64'(bus32.out_valid), 64'd0);
        check("rst_busy", 64'(busy32), 64'd0);
        check("rst_out_data", bus32.out_data, 64'd0);
        check("rst_busy_r1", 64'(busy1), 64'd0);
        step();
        rst_n = 1'b1;
        step();

        // Known answer: key 0, plaintext 0, 32 rounds
        accept32(64'd0, 128'd0, ok);
        check("kat_accept", 64'(ok), 64'd1);
        wait_done32(n);
        check("kat_latency", 64'(n), 64'd33);
        check("kat_data", bus32.out_data, CT_ZERO);
        check("kat_busy", 64'(busy32), 64'd1);
        check("kat_in_ready", 64'(bus32.in_ready), 64'd0);
        check("kat_sum", 64'(dut.r_sum), 64'(TEA_SUM32));
        take32();
        check("kat_out_valid_clr", 64'(bus32.out_valid), 64'd0);
        check("kat_in_ready_back", 64'(bus32.in_ready), 64'd1);

        // Single-round instance
        bus1.in_valid = 1'b1;
        bus1.in_data  = '0;
        bus1.in_key   = '0;
        check("r1_in_ready", 64'(bus1.in_ready), 64'd1);
        step();
        bus1.in_valid = 1'b0;
        n = 1;
        while (!bus1.out_valid && n < 20) begin
            step();
            n++;
        end
        check("r1_latency", 64'(n), 64'd2);
        check("r1_data", bus1.out_data, CT_ZERO_R1);
        bus1.out_ready = 1'b1;
        step();
        bus1.out_ready = 1'b0;
        check("r1_out_valid_clr", 64'(bus1.out_valid), 64'd0);

        // Round trips with KEY_A; junk offered on the inputs while running
        for (int b = 0; b < 40; b++) begin
            pt = {$urandom(), $urandom()};
            accept32(pt, KEY_A, ok);
            check("rt_accept", 64'(ok), 64'd1);
            bus32.in_valid = 1'b1;
            bus32.in_data  = {$urandom(), $urandom()};
            bus32.in_key   = {$urandom(), $urandom(), $urandom(), $urandom()};
            step();
            bus32.in_valid = 1'b0;
            wait_done32(n);
            check("rt_valid", 64'(bus32.out_valid), 64'd1);
            check("rt_plain", tea_dec(bus32.out_data, KEY_A), pt);
            take32();
        end

        // Output back-pressure with a second job offered during DONE
        accept32(64'd0, 128'd0, ok);
        wait_done32(n);
        check("hold_first", bus32.out_data, CT_ZERO);
        held = bus32.out_data;
        for (int i = 0; i < 20; i++) begin
            if (i == 5) begin
                bus32.in_valid = 1'b1;
                bus32.in_data  = PT_B;
                bus32.in_key   = KEY_A;
            end
            check("hold_data", bus32.out_data, held);
            check("hold_in_ready", 64'(bus32.in_ready), 64'd0);
            step();
        end
        check("hold_still_valid", 64'(bus32.out_valid), 64'd1);
        take32();
        check("hold_hs_valid", 64'(bus32.out_valid), 64'd0);
        check("hold_not_yet_busy", 64'(busy32), 64'd0);
        check("hold_in_ready", 64'(bus32.in_ready), 64'd1);
        step();
        bus32.in_valid = 1'b0;
        check("hold_second_busy", 64'(busy32), 64'd1);
        wait_done32(n);
        check("hold_second_latency", 64'(n), 64'd33);
        check("hold_second_plain", tea_dec(bus32.out_data, KEY_A), PT_B);
        take32();

        // Reset in the middle of a job
        accept32(64'd0, 128'd0, ok);
        repeat (10) step();
        rst_n = 1'b0;
        #1;
        check("mid_rst_in_ready", 64'(bus32.in_ready), 64'd1);
        check("mid_rst_out_valid", 64'(bus32.out_valid), 64'd0);
        check("mid_rst_busy", 64'(busy32), 64'd0);
        check("mid_rst_out_data", bus32.out_data, 64'd0);
        repeat (3) step();
        check("mid_rst_hold_valid", 64'(bus32.out_valid), 64'd0);
        rst_n = 1'b1;
        step();
        accept32(64'd0, 128'd0, ok);
        wait_done32(n);
        check("post_rst_latency", 64'(n), 64'd33);
        check("post_rst_data", bus32.out_data, CT_ZERO);
        take32();

        // Back-to-back with out_ready and in_valid held high
        bus32.out_ready = 1'b1;
        bus32.in_valid  = 1'b1;
        bus32.in_data   = '0;
        bus32.in_key    = '0;
        n = 0;
        while (!bus32.out_valid && n < 100) begin
            step();
            n++;
        end
        check("b2b_first", bus32.out_data, CT_ZERO);
        step();
        check("b2b_in_ready", 64'(bus32.in_ready), 64'd1);
        check("b2b_valid_clr", 64'(bus32.out_valid), 64'd0);
        n = 1;
        while (!bus32.out_valid && n < 100) begin
            step();
            n++;
        end
        check("b2b_period", 64'(n), 64'd34);
        check("b2b_second", bus32.out_data, CT_ZERO);
        bus32.in_valid = 1'b0;
        step();
        bus32.out_ready = 1'b0;
        repeat (2) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
